// File: rtl/vlsu_axi_mem_responder.sv
`timescale 1ns/1ps
// AXI4 subordinate backed by a word-addressed scratchpad memory.
// Independent read and write FSMs, each serving one outstanding INCR burst.
module vlsu_axi_mem_responder #(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MemDepth     = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // read address
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AxiIdWidth-1:0]     ar_id_i,
    input  logic [AxiAddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]                ar_len_i,
    // read data
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [AxiIdWidth-1:0]     r_id_o,
    output logic [AxiDataWidth-1:0]   r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o,
    // write address
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    // write data
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    // write response
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o
);

    localparam int unsigned NB    = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(NB);
    localparam int unsigned IdxW  = AxiAddrWidth - OffW;
    localparam int unsigned MemAw = $clog2(MemDepth);

    localparam logic [IdxW-1:0] DepthIdx   = IdxW'(MemDepth);
    localparam logic [1:0]      RespOkay   = 2'b00;
    localparam logic [1:0]      RespSlvErr = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    logic [AxiDataWidth-1:0] mem_q [MemDepth];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e              r_state_q, r_state_d;
    logic [AxiIdWidth-1:0] r_id_q,    r_id_d;
    logic [IdxW-1:0]       r_idx_q,   r_idx_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [7:0]            r_beat_q,  r_beat_d;

    logic r_burst;
    logic r_in_range;
    logic r_last;

    assign r_burst    = (r_state_q == R_BURST);
    assign r_in_range = (r_idx_q < DepthIdx);
    assign r_last     = r_burst && (r_beat_q == r_len_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    r_id_d    = ar_id_i;
                    r_idx_d   = ar_addr_i[AxiAddrWidth-1:OffW];
                    r_len_d   = ar_len_i;
                    r_beat_d  = '0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_ready_i) begin
                    r_idx_d  = r_idx_q + IdxW'(1);
                    r_beat_d = r_beat_q + 8'd1;
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Outputs derive only from registered burst state, so they hold while stalled.
    assign ar_ready_o = (r_state_q == R_IDLE) && !rst_i;
    assign r_valid_o  = r_burst;
    assign r_id_o     = r_burst ? r_id_q : '0;
    assign r_data_o   = (r_burst && r_in_range) ? mem_q[r_idx_q[MemAw-1:0]] : '0;
    assign r_resp_o   = (r_burst && !r_in_range) ? RespSlvErr : RespOkay;
    assign r_last_o   = r_last;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e              w_state_q, w_state_d;
    logic [AxiIdWidth-1:0] w_id_q,    w_id_d;
    logic [IdxW-1:0]       w_idx_q,   w_idx_d;
    logic                  w_err_q,   w_err_d;

    logic w_in_range;
    logic w_hs;
    logic mem_we;

    assign w_in_range = (w_idx_q < DepthIdx);
    assign w_hs       = (w_state_q == W_DATA) && w_valid_i;
    assign mem_we     = w_hs && w_in_range;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    w_id_d    = aw_id_i;
                    w_idx_d   = aw_addr_i[AxiAddrWidth-1:OffW];
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // The burst ends on w_last_i; the AW length is advisory only.
                if (w_valid_i) begin
                    w_idx_d = w_idx_q + IdxW'(1);
                    if (!w_in_range) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_i) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign aw_ready_o = (w_state_q == W_IDLE) && !rst_i;
    assign w_ready_o  = (w_state_q == W_DATA);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = (w_state_q == W_RESP) ? w_id_q : '0;
    assign b_resp_o   = ((w_state_q == W_RESP) && w_err_q) ? RespSlvErr : RespOkay;

    // Storage is never reset; a same-cycle read sees the old word.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w_strb_i[b]) begin
                    mem_q[w_idx_q[MemAw-1:0]][b*8 +: 8] <= w_data_i[b*8 +: 8];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ar_addr_i[OffW-1:0], aw_addr_i[OffW-1:0], aw_len_i};

endmodule
